// File: rtl/alu_seq_if.sv
// ALU request/response bundle: operands and function code in, status and result out.
// The master issues requests with start. The slave reports busy/done and holds the result.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [4:0]       func;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output start, func, a, b, carry_in,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, func, a, b, carry_in,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops, bit-serial shifts/rotate, shift-add multiply.
// Latency accept->done: 1 cycle, n+1 for shifts (n>0), WIDTH+1 for multiply.
// No backpressure; start is sampled only in IDLE, and a start while busy is dropped.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter int SHW    = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  alu_seq_if.slave   s_if
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [4:0] FN_A    = 5'd0;
  localparam logic [4:0] FN_B    = 5'd1;
  localparam logic [4:0] FN_ADD  = 5'd2;
  localparam logic [4:0] FN_ADC  = 5'd3;
  localparam logic [4:0] FN_SUB  = 5'd4;
  localparam logic [4:0] FN_SUC  = 5'd5;
  localparam logic [4:0] FN_NEG  = 5'd6;
  localparam logic [4:0] FN_AND  = 5'd7;
  localparam logic [4:0] FN_OR   = 5'd8;
  localparam logic [4:0] FN_XOR  = 5'd9;
  localparam logic [4:0] FN_NOT  = 5'd10;
  localparam logic [4:0] FN_NAND = 5'd11;
  localparam logic [4:0] FN_NOR  = 5'd12;
  localparam logic [4:0] FN_LSL  = 5'd13;
  localparam logic [4:0] FN_LSR  = 5'd14;
  localparam logic [4:0] FN_ASR  = 5'd15;
  localparam logic [4:0] FN_LUI  = 5'd16;
  localparam logic [4:0] FN_LLI  = 5'd17;
  localparam logic [4:0] FN_MUL  = 5'd18;
  localparam logic [4:0] FN_ROR  = 5'd19;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic [4:0]         r_func;
  logic [WIDTH-1:0]   r_a;       // multiplicand for MUL
  logic [2*WIDTH-1:0] r_work;    // MUL: {partial hi, multiplier/low}; shifts use low half
  logic [CW-1:0]      r_cnt;

  assign s_if.busy   = r_busy;
  assign s_if.done   = r_done;
  assign s_if.result = r_result;
  assign s_if.flags  = r_flags;

  // Accept-path decode and single-cycle datapath, computed straight from the live inputs
  logic [SHW-1:0]   w_n;
  logic             w_is_shift;
  logic             w_is_mul;
  logic             w_go_iter;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_ci;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_keep;
  logic [3:0]       w_flags;

  // Decode the request and produce the one-cycle result and next flags
  always_comb begin
    w_n        = s_if.b[SHW-1:0];
    w_is_shift = (s_if.func == FN_LSL) || (s_if.func == FN_LSR) ||
                 (s_if.func == FN_ASR) || (s_if.func == FN_ROR);
    w_is_mul   = (s_if.func == FN_MUL) && (MUL_EN != 0);
    w_go_iter  = (w_is_shift && (w_n != '0)) || w_is_mul;

    // Every add/subtract variant maps onto x + y + ci
    w_x  = s_if.a;
    w_y  = s_if.b;
    w_ci = 1'b0;
    case (s_if.func)
      FN_ADC: w_ci = s_if.carry_in;
      FN_SUB: begin w_y = ~s_if.b; w_ci = 1'b1; end
      FN_SUC: begin w_y = ~s_if.b; w_ci = s_if.carry_in; end
      FN_NEG: begin w_x = '0; w_y = ~s_if.a; w_ci = 1'b1; end
      default: ;
    endcase
    w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};

    w_res  = s_if.a;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_keep = 1'b0;
    case (s_if.func)
      FN_A:    w_res = s_if.a;
      FN_B:    w_res = s_if.b;
      FN_ADD, FN_ADC, FN_SUB, FN_SUC, FN_NEG: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
      end
      FN_AND:  w_res = s_if.a & s_if.b;
      FN_OR:   w_res = s_if.a | s_if.b;
      FN_XOR:  w_res = s_if.a ^ s_if.b;
      FN_NOT:  w_res = ~s_if.a;
      FN_NAND: w_res = ~(s_if.a & s_if.b);
      FN_NOR:  w_res = ~(s_if.a | s_if.b);
      // Only reached here with n=0: value passes through, C=0
      FN_LSL, FN_LSR, FN_ASR, FN_ROR: w_res = s_if.a;
      FN_LUI: begin w_res = {s_if.b[H-1:0], s_if.a[H-1:0]};     w_keep = 1'b1; end
      FN_LLI: begin w_res = {s_if.a[WIDTH-1:H], s_if.b[H-1:0]}; w_keep = 1'b1; end
      // Illegal codes (and MUL when disabled): pass A, flags untouched
      default: begin w_res = s_if.a; w_keep = 1'b1; end
    endcase
    w_flags = w_keep ? r_flags : {w_res[WIDTH-1], w_v, w_c, (w_res == '0)};
  end

  // One iteration step of the latched operation
  logic [WIDTH-1:0]   w_shv;
  logic [WIDTH-1:0]   w_sh_nx;
  logic               w_sh_out;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nx;
  logic               w_it_mul;
  logic [2*WIDTH-1:0] w_step;
  logic [WIDTH-1:0]   w_it_res;
  logic               w_it_c;
  logic [3:0]         w_it_flags;

  // Advance shift by one bit or multiply by one partial product
  always_comb begin
    w_shv    = r_work[WIDTH-1:0];
    w_sh_nx  = w_shv;
    w_sh_out = 1'b0;
    case (r_func)
      FN_LSL: begin w_sh_nx = {w_shv[WIDTH-2:0], 1'b0};        w_sh_out = w_shv[WIDTH-1]; end
      FN_LSR: begin w_sh_nx = {1'b0, w_shv[WIDTH-1:1]};        w_sh_out = w_shv[0]; end
      FN_ASR: begin w_sh_nx = {w_shv[WIDTH-1], w_shv[WIDTH-1:1]}; w_sh_out = w_shv[0]; end
      FN_ROR: begin w_sh_nx = {w_shv[0], w_shv[WIDTH-1:1]};    w_sh_out = w_shv[0]; end
      default: ;
    endcase

    w_mul_sum = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_work[0] ? {1'b0, r_a} : '0);
    w_mul_nx  = {w_mul_sum, r_work[WIDTH-1:1]};

    w_it_mul = (r_func == FN_MUL);
    if (w_it_mul) begin
      w_step   = w_mul_nx;
      w_it_res = w_mul_nx[WIDTH-1:0];
      w_it_c   = (w_mul_nx[2*WIDTH-1:WIDTH] != '0);
    end else begin
      w_step   = {r_work[2*WIDTH-1:WIDTH], w_sh_nx};
      w_it_res = w_sh_nx;
      w_it_c   = w_sh_out;
    end
    // MUL reports high-half overflow on both C and V; shifts clear V
    w_it_flags = {w_it_res[WIDTH-1], (w_it_mul & w_it_c), w_it_c, (w_it_res == '0)};
  end

  // Control FSM with registered status, result and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
      r_func   <= '0;
      r_a      <= '0;
      r_work   <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (s_if.start) begin
            r_busy <= 1'b1;
            r_func <= s_if.func;
            r_a    <= s_if.a;
            if (w_go_iter) begin
              r_state <= S_ITER;
              r_work  <= w_is_mul ? {{WIDTH{1'b0}}, s_if.b} : {{WIDTH{1'b0}}, s_if.a};
              r_cnt   <= w_is_mul ? CNT_WIDTH : {{(CW-SHW){1'b0}}, w_n};
            end else begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_result <= w_res;
              r_flags  <= w_flags;
            end
          end
        end
        S_ITER: begin
          r_work <= w_step;
          r_cnt  <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_result <= w_it_res;
            r_flags  <= w_it_flags;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed vectors with hand-computed results.
// The stimulus process pushes the expected result, flags and latency; the monitor pops on done.
// Also covers the reset state, operand latching, start-while-busy and reset abort.
module tb_alu_seq;

  localparam logic [4:0] F_A = 5'd0, F_B = 5'd1, F_ADD = 5'd2, F_ADC = 5'd3, F_SUB = 5'd4;
  localparam logic [4:0] F_SUC = 5'd5, F_NEG = 5'd6, F_AND = 5'd7, F_OR = 5'd8, F_XOR = 5'd9;
  localparam logic [4:0] F_NOT = 5'd10, F_NAND = 5'd11, F_NOR = 5'd12, F_LSL = 5'd13;
  localparam logic [4:0] F_LSR = 5'd14, F_ASR = 5'd15, F_LUI = 5'd16, F_LLI = 5'd17;
  localparam logic [4:0] F_MUL = 5'd18, F_ROR = 5'd19;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;   // {N, V, C, Z}
    int          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cycle = 0;
  int   n_vec = 0;
  int   fails = 0;
  exp_t sb[$];

  alu_seq_if #(.WIDTH(16)) u_if ();

  alu_seq #(.WIDTH(16)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  exp_t m_e;
  always @(negedge clk) begin
    if (!rst && u_if.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        fails++;
        $display("FAIL unexpected_done: got result %h flags %b, expected no done", u_if.result, u_if.flags);
      end else begin
        m_e = sb.pop_front();
        chk("result",  {16'h0, u_if.result}, {16'h0, m_e.res});
        chk("flags",   {28'h0, u_if.flags},  {28'h0, m_e.flg});
        chk("latency", cycle - m_e.acc + 1,  m_e.lat);
        chk("busy_in_done", {31'h0, u_if.busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (u_if.busy === 1'b1 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (u_if.busy === 1'b1) begin
      n_vec++;
      fails++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0");
    end
  endtask

  task automatic do_op(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic [15:0] er, input logic [3:0] ef,
                       input int el, input bit poke);
    exp_t e;
    int   t;
    wait_idle();
    @(negedge clk);
    u_if.func = f; u_if.a = a; u_if.b = b; u_if.carry_in = ci; u_if.start = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs right after acceptance: the operation must use latched values
    u_if.start = 1'b0; u_if.a = ~a; u_if.b = b ^ 16'h5A5A; u_if.carry_in = ~ci; u_if.func = F_XOR;
    e.res = er; e.flg = ef; e.lat = el; e.acc = cycle;
    sb.push_back(e);
    if (poke) begin
      repeat (5) @(negedge clk);
      u_if.start = 1'b1; u_if.func = F_ADD;
      @(negedge clk);
      u_if.start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      fails++;
      $display("FAIL done_timeout func=%0d: got no done, expected result %h", f, er);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    u_if.start = 1'b0; u_if.func = '0; u_if.a = '0; u_if.b = '0; u_if.carry_in = 1'b0;
    #1;
    chk("rst_busy",   {31'h0, u_if.busy},   32'd0);
    chk("rst_done",   {31'h0, u_if.done},   32'd0);
    chk("rst_result", {16'h0, u_if.result}, 32'd0);
    chk("rst_flags",  {28'h0, u_if.flags},  32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    //     func    A        B        ci    result   NVCZ     lat poke
    do_op(F_ADD,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100, 1,  0);
    do_op(F_SUB,  16'h0005, 16'h0005, 1'b0, 16'h0000, 4'b0011, 1,  0);
    do_op(F_SUB,  16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b1000, 1,  0);
    do_op(F_ASR,  16'h8000, 16'h0004, 1'b0, 16'hF800, 4'b1000, 5,  0);
    do_op(F_ASR,  16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b1000, 1,  0);
    do_op(F_MUL,  16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0111, 17, 1);
    do_op(F_MUL,  16'h0003, 16'h0005, 1'b0, 16'h000F, 4'b0000, 17, 0);
    do_op(F_MUL,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 4'b0110, 17, 0);
    do_op(F_SUB,  16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 4'b1010, 1,  0);
    do_op(F_LUI,  16'h1234, 16'h00AB, 1'b0, 16'hAB34, 4'b1010, 1,  0);
    do_op(5'd25,  16'h5A5A, 16'h1111, 1'b0, 16'h5A5A, 4'b1010, 1,  0);
    do_op(F_LLI,  16'h1234, 16'h00CD, 1'b0, 16'h12CD, 4'b1010, 1,  0);
    do_op(F_ADC,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0011, 1,  0);
    do_op(F_SUC,  16'h0005, 16'h0003, 1'b0, 16'h0001, 4'b0010, 1,  0);
    do_op(F_NEG,  16'h0001, 16'h0000, 1'b0, 16'hFFFF, 4'b1000, 1,  0);
    do_op(F_NEG,  16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b1100, 1,  0);
    do_op(F_AND,  16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 4'b0000, 1,  0);
    do_op(F_XOR,  16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0001, 1,  0);
    do_op(F_NOT,  16'h00FF, 16'h0000, 1'b0, 16'hFF00, 4'b1000, 1,  0);
    do_op(F_OR,   16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0001, 1,  0);
    do_op(F_NAND, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 4'b0001, 1,  0);
    do_op(F_NOR,  16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b1000, 1,  0);
    do_op(F_A,    16'h8000, 16'h0001, 1'b0, 16'h8000, 4'b1000, 1,  0);
    do_op(F_B,    16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0001, 1,  0);
    do_op(F_LSL,  16'h8001, 16'h0011, 1'b0, 16'h0002, 4'b0010, 2,  0);
    do_op(F_LSR,  16'h0003, 16'h0002, 1'b0, 16'h0000, 4'b0011, 3,  0);
    do_op(F_ASR,  16'h8000, 16'h000F, 1'b0, 16'hFFFF, 4'b1000, 16, 0);
    do_op(F_ROR,  16'h0001, 16'h0001, 1'b0, 16'h8000, 4'b1010, 2,  0);

    // Reset in the third ITER cycle of an 8-bit LSL: everything clears, no done afterwards
    wait_idle();
    @(negedge clk);
    u_if.func = F_LSL; u_if.a = 16'h0001; u_if.b = 16'h0008; u_if.start = 1'b1;
    @(posedge clk);
    #1 u_if.start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy",   {31'h0, u_if.busy},   32'd0);
    chk("abort_done",   {31'h0, u_if.done},   32'd0);
    chk("abort_result", {16'h0, u_if.result}, 32'd0);
    chk("abort_flags",  {28'h0, u_if.flags},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    do_op(F_ADD, 16'h0001, 16'h0002, 1'b0, 16'h0003, 4'b0000, 1, 0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; SHALL be even and >=8.
REQ-002 Parameter: SHW, $clog2(WIDTH), shift-amount field width taken from B[SHW-1:0].
REQ-003 Parameter: MUL_EN, 1, enables FnMUL; when 0, FnMUL SHALL be treated as an illegal code.
REQ-004 Port: Clock  in  1  single clock; all state changes on the rising edge.
REQ-005 Port: Reset  in  1  asynchronous, active-high reset.
REQ-006 Port: Start  in  1  request; sampled only in IDLE.
REQ-007 Port: Func  in  5  function code: FnA=0, FnB=1, FnADD=2, FnADC=3, FnSUB=4, FnSUC=5, FnNEG=6, FnAND=7, FnOR=8, FnXOR=9, FnNOT=10, FnNAND=11, FnNOR=12, FnLSL=13, FnLSR=14, FnASR=15, FnLUI=16, FnLLI=17 (existing encoding); new FnMUL=18, FnROR=19; 20-31 illegal.
REQ-008 Port: A, B  in  WIDTH  operands; captured with Func and CarryIn on the accepting edge.
REQ-009 Port: CarryIn  in  1  carry for FnADC/FnSUC.
REQ-010 Port: Busy  out  1  high while not IDLE.
REQ-011 Port: Done  out  1  one-cycle completion pulse.
REQ-012 Port: Result  out  WIDTH  registered result; holds until next completion.
REQ-013 Port: Flags  out  4  registered flags; bit0 Z, bit1 C, bit2 V, bit3 N.

Function
REQ-014 States SHALL be IDLE, ITER, DONE; IDLE+Start -> ITER for shifts with amount n>0 and FnMUL, else -> DONE; ITER -> DONE when the iteration counter expires; DONE -> IDLE unconditionally.
REQ-015 Done SHALL be high exactly in DONE; Result/Flags SHALL update on the edge entering DONE.
REQ-016 Operands SHALL be latched on acceptance; later input changes SHALL not affect the operation.
REQ-017 Start while Busy SHALL be ignored (no queueing).
REQ-018 Latency (accept edge to Done high): 1 cycle for non-iterative ops and shifts with n=0; n+1 cycles for shifts with n>0; WIDTH+1 cycles for FnMUL.
REQ-019 Shifts (LSL, LSR, ASR, ROR) SHALL move one bit per ITER cycle; n=B[SHW-1:0]; upper B bits ignored.
REQ-020 FnMUL SHALL be unsigned shift-add over WIDTH cycles; Result = low WIDTH bits of A*B.
REQ-021 Arithmetic: ADD=A+B, ADC=A+B+CarryIn, SUB=A+~B+1, SUC=A+~B+CarryIn, NEG=0-A; C = carry out of the (WIDTH+1)-bit sum (1 = no borrow); V = signed two's-complement overflow.
REQ-022 FnLUI Result={B[WIDTH/2-1:0], A[WIDTH/2-1:0]}; FnLLI Result={A[WIDTH-1:WIDTH/2], B[WIDTH/2-1:0]}; both leave Flags unchanged.
REQ-023 Z=(Result==0) and N=Result[WIDTH-1] SHALL update for all ops except LUI, LLI, illegal.
REQ-024 FnA, FnB and logic ops SHALL clear C and V.
REQ-025 Shifts SHALL set C to the last bit shifted out (0 when n=0) and clear V.
REQ-026 FnMUL SHALL set C=V=1 iff the high WIDTH bits of the full product are nonzero.
REQ-027 Illegal codes SHALL take the 1-cycle path with Result=A and Flags unchanged.

Reset
REQ-028 Reset high SHALL force, asynchronously: state IDLE, Busy=0, Done=0, Result=0, Flags=0, counter=0.
REQ-029 Reset during ITER or DONE SHALL abort the operation with no Done pulse; the first Start after release SHALL be accepted normally.

Verification
REQ-030 WIDTH=16: FnADD A=7FFF B=0001 -> Done one cycle after accept, Result=8000, Flags Z0 C0 V1 N1.
REQ-031 FnSUB A=0005 B=0005 -> Result=0000, Z=1, C=1, V=0, N=0; FnSUB A=0000 B=0001 -> FFFF, C=0, N=1.
REQ-032 FnASR A=8000 B=0004 -> Busy 4 cycles, Done at cycle 5, Result=F800, C=0, N=1; same with B=0000 -> Done at cycle 1, Result=8000, C=0.
REQ-033 FnMUL A=0100 B=0100 -> Done at cycle 17, Result=0000, Z=1, C=V=1; Start pulsed mid-operation is ignored.
REQ-034 FnLUI A=1234 B=00AB with prior Flags=1010 -> Result=AB34, Flags stay 1010; Func=25 -> Result=A, Flags unchanged.
REQ-035 Reset asserted at ITER cycle 3 of FnLSL -> Busy, Done, Result and Flags go 0 immediately; no Done pulse follows.
